// File: rtl/alu_issue_ctrl.sv
// Valid/ready issue front-end for the 32-bit ripple-carry ALU: decodes R-type funct,
// launches operands, captures masked flags after SETTLE_CYCLES. Optional trap: ALU_ISSUE_TRAP_EN.
`timescale 1ns/1ps
module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_funct,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_zero,
   output logic        resp_cout,
   output logic        resp_overflow,
   output logic        resp_trap,
   output logic        resp_illegal,
   output logic        ovf_sticky,
   input  logic        stat_clr,
   output logic        alu_rst_n,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_cout,
   input  logic        alu_overflow
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("alu_issue_ctrl: SETTLE_CYCLES must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Returns {legal, alu_control}.
   function automatic logic [4:0] decode_funct(input logic [5:0] f);
      logic [4:0] d;
      case (f)
         6'h24:         d = {1'b1, 4'b0000};
         6'h25:         d = {1'b1, 4'b0001};
         6'h20, 6'h21:  d = {1'b1, 4'b0010};
         6'h22, 6'h23:  d = {1'b1, 4'b0110};
         6'h2A:         d = {1'b1, 4'b0111};
         6'h27:         d = {1'b1, 4'b1100};
         6'h2E:         d = {1'b1, 4'b1101};
         default:       d = {1'b0, 4'b0000};
      endcase
      return d;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] src1_q, src1_d;
   logic [31:0] src2_q, src2_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic        trap_op_q, trap_op_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;
   logic        trap_q, trap_d;
   logic        illegal_q, illegal_d;
   logic        sticky_q, sticky_d;
   logic        alu_rst_n_q;

   logic [4:0]  dec_s;
   logic        addsub_s;
   logic        ovf_m_s;
   logic        trap_s;
   logic        sticky_set_s;

   assign dec_s    = decode_funct(req_funct);
   assign addsub_s = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);
   assign ovf_m_s  = addsub_s & alu_overflow;

   // Trap only for the signed add/sub functs that launched the current operation.
`ifdef ALU_ISSUE_TRAP_EN
   assign trap_s = trap_op_q & ovf_m_s;
`else
   assign trap_s = 1'b0;
`endif

   // Next-state and datapath register update for the issue FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      ctrl_d       = ctrl_q;
      trap_op_d    = trap_op_q;
      result_d     = result_q;
      zero_d       = zero_q;
      cout_d       = cout_q;
      ovf_d        = ovf_q;
      trap_d       = trap_q;
      illegal_d    = illegal_q;
      sticky_set_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (dec_s[4]) begin
                  state_d   = WAIT;
                  cnt_d     = 4'(SETTLE_CYCLES);
                  src1_d    = req_a;
                  src2_d    = req_b;
                  ctrl_d    = dec_s[3:0];
                  trap_op_d = (req_funct == 6'h20) || (req_funct == 6'h22);
               end else begin
                  state_d   = RESP;
                  result_d  = 32'd0;
                  zero_d    = 1'b0;
                  cout_d    = 1'b0;
                  ovf_d     = 1'b0;
                  trap_d    = 1'b0;
                  illegal_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d      = RESP;
               result_d     = trap_s ? 32'd0 : alu_result;
               zero_d       = alu_zero;
               cout_d       = addsub_s & alu_cout;
               ovf_d        = ovf_m_s;
               trap_d       = trap_s;
               illegal_d    = 1'b0;
               sticky_set_s = ovf_m_s;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Set has priority over a coincident clear.
      if (sticky_set_s) begin
         sticky_d = 1'b1;
      end else if (stat_clr) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         src1_q    <= 32'd0;
         src2_q    <= 32'd0;
         ctrl_q    <= 4'b0000;
         trap_op_q <= 1'b0;
         result_q  <= 32'd0;
         zero_q    <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         trap_q    <= 1'b0;
         illegal_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         ctrl_q    <= ctrl_d;
         trap_op_q <= trap_op_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         trap_q    <= trap_d;
         illegal_q <= illegal_d;
         sticky_q  <= sticky_d;
      end
   end

   // Registered reset forwarded to the ALU.
   always_ff @(posedge clk) begin
      alu_rst_n_q <= rst_n;
   end

   assign req_ready     = (state_q == IDLE);
   assign resp_valid    = (state_q == RESP);
   assign resp_result   = result_q;
   assign resp_zero     = zero_q;
   assign resp_cout     = cout_q;
   assign resp_overflow = ovf_q;
   assign resp_trap     = trap_q;
   assign resp_illegal  = illegal_q;
   assign ovf_sticky    = sticky_q;
   assign alu_rst_n     = alu_rst_n_q;
   assign alu_src1      = src1_q;
   assign alu_src2      = src2_q;
   assign alu_control   = ctrl_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with SETTLE_CYCLES=1, one with 4,
// each driven by a behavioural ALU that leaves garbage carry/overflow on logic ops.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef ALU_ISSUE_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // {cout, overflow, result}; non-add/sub codes report carry=overflow=1 as stale junk.
   function automatic logic [33:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic        v;
      case (c)
         4'b0000: return {2'b11, a & b};
         4'b0001: return {2'b11, a | b};
         4'b0010: begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (s[31] != a[31]);
            return {s[32], v, s[31:0]};
         end
         4'b0110: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (s[31] != a[31]);
            return {s[32], v, s[31:0]};
         end
         4'b0111: return {2'b11, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
         4'b1100: return {2'b11, ~(a | b)};
         4'b1101: return {2'b11, ~(a & b)};
         default: return {2'b00, 32'd0};
      endcase
   endfunction

   // Instance with SETTLE_CYCLES=1
   logic rst1_n = 1'b0, req_valid1 = 1'b0, resp_ready1 = 1'b0, stat_clr1 = 1'b0;
   logic [5:0] req_funct1 = 6'd0;
   logic [31:0] req_a1 = 32'd0, req_b1 = 32'd0;
   logic req_ready1, resp_valid1, resp_zero1, resp_cout1, resp_overflow1, resp_trap1, resp_illegal1;
   logic ovf_sticky1, alu_rst_n1, alu_zero1, alu_cout1, alu_overflow1;
   logic [31:0] resp_result1, alu_src1_1, alu_src2_1, alu_result1;
   logic [3:0] alu_control1;

   assign {alu_cout1, alu_overflow1, alu_result1} = alu_model(alu_control1, alu_src1_1, alu_src2_1);
   assign alu_zero1 = (alu_result1 == 32'd0);

   alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_funct(req_funct1), .req_a(req_a1), .req_b(req_b1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_result(resp_result1),
      .resp_zero(resp_zero1), .resp_cout(resp_cout1), .resp_overflow(resp_overflow1),
      .resp_trap(resp_trap1), .resp_illegal(resp_illegal1), .ovf_sticky(ovf_sticky1),
      .stat_clr(stat_clr1), .alu_rst_n(alu_rst_n1), .alu_src1(alu_src1_1), .alu_src2(alu_src2_1),
      .alu_control(alu_control1), .alu_result(alu_result1), .alu_zero(alu_zero1),
      .alu_cout(alu_cout1), .alu_overflow(alu_overflow1)
   );

   // Instance with SETTLE_CYCLES=4
   logic rst4_n = 1'b0, req_valid4 = 1'b0, resp_ready4 = 1'b0, stat_clr4 = 1'b0;
   logic [5:0] req_funct4 = 6'd0;
   logic [31:0] req_a4 = 32'd0, req_b4 = 32'd0;
   logic req_ready4, resp_valid4, resp_zero4, resp_cout4, resp_overflow4, resp_trap4, resp_illegal4;
   logic ovf_sticky4, alu_rst_n4, alu_zero4, alu_cout4, alu_overflow4;
   logic [31:0] resp_result4, alu_src1_4, alu_src2_4, alu_result4;
   logic [3:0] alu_control4;

   assign {alu_cout4, alu_overflow4, alu_result4} = alu_model(alu_control4, alu_src1_4, alu_src2_4);
   assign alu_zero4 = (alu_result4 == 32'd0);

   alu_issue_ctrl #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_funct(req_funct4), .req_a(req_a4), .req_b(req_b4),
      .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_result(resp_result4),
      .resp_zero(resp_zero4), .resp_cout(resp_cout4), .resp_overflow(resp_overflow4),
      .resp_trap(resp_trap4), .resp_illegal(resp_illegal4), .ovf_sticky(ovf_sticky4),
      .stat_clr(stat_clr4), .alu_rst_n(alu_rst_n4), .alu_src1(alu_src1_4), .alu_src2(alu_src2_4),
      .alu_control(alu_control4), .alu_result(alu_result4), .alu_zero(alu_zero4),
      .alu_cout(alu_cout4), .alu_overflow(alu_overflow4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request at a negedge; returns 1 ns after the accepting edge T.
   task automatic send1(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      chk("ready1_before_send", req_ready1, 32'd1);
      req_valid1 = 1'b1; req_funct1 = f; req_a1 = a; req_b1 = b;
      @(posedge clk);
      #1 req_valid1 = 1'b0;
   endtask

   task automatic send4(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      chk("ready4_before_send", req_ready4, 32'd1);
      req_valid4 = 1'b1; req_funct4 = f; req_a4 = a; req_b4 = b;
      @(posedge clk);
      #1 req_valid4 = 1'b0;
   endtask

   // Called at a negedge while resp_valid1 is high.
   task automatic accept1();
      resp_ready1 = 1'b1;
      @(posedge clk);
      #1 resp_ready1 = 1'b0;
      @(negedge clk);
      chk("accept1_valid_low", resp_valid1, 32'd0);
      chk("accept1_ready_high", req_ready1, 32'd1);
   endtask

   task automatic accept4();
      resp_ready4 = 1'b1;
      @(posedge clk);
      #1 resp_ready4 = 1'b0;
      @(negedge clk);
      chk("accept4_valid_low", resp_valid4, 32'd0);
      chk("accept4_ready_high", req_ready4, 32'd1);
   endtask

   initial begin
      // Reset both instances.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", resp_valid1, 32'd0);
      chk("rst_resp_result", resp_result1, 32'd0);
      chk("rst_sticky", ovf_sticky1, 32'd0);
      chk("rst_alu_rst_n", alu_rst_n1, 32'd0);
      chk("rst_alu_control", alu_control1, 32'd0);
      chk("rst_alu_src1", alu_src1_1, 32'd0);
      chk("rst_req_ready", req_ready1, 32'd1);
      rst1_n = 1'b1;
      rst4_n = 1'b1;
      @(negedge clk);
      chk("alu_rst_n_released", alu_rst_n1, 32'd1);
      chk("ready_after_release", req_ready1, 32'd1);

      // ADD 5+3, response one edge after acceptance.
      send1(6'h20, 32'h0000_0005, 32'h0000_0003);
      @(negedge clk);
      chk("add_valid_not_yet", resp_valid1, 32'd0);
      chk("add_alu_control", alu_control1, 32'h2);
      chk("add_ready_low", req_ready1, 32'd0);
      @(negedge clk);
      chk("add_valid", resp_valid1, 32'd1);
      chk("add_result", resp_result1, 32'h0000_0008);
      chk("add_zero", resp_zero1, 32'd0);
      chk("add_cout", resp_cout1, 32'd0);
      chk("add_ovf", resp_overflow1, 32'd0);
      chk("add_illegal", resp_illegal1, 32'd0);
      accept1();

      // SUB 0x7FFFFFFF - 0xFFFFFFFF overflows.
      send1(6'h22, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      chk("sub_valid", resp_valid1, 32'd1);
      chk("sub_ovf", resp_overflow1, 32'd1);
      chk("sub_cout", resp_cout1, 32'd0);
      chk("sub_sticky", ovf_sticky1, 32'd1);
      chk("sub_trap", resp_trap1, {31'd0, TRAP});
      chk("sub_result", resp_result1, TRAP ? 32'd0 : 32'h8000_0000);
      accept1();

      // AND: ALU model reports stale carry/overflow=1, which must be masked.
      send1(6'h24, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      @(negedge clk);
      @(negedge clk);
      chk("and_result", resp_result1, 32'd0);
      chk("and_zero", resp_zero1, 32'd1);
      chk("and_cout_masked", resp_cout1, 32'd0);
      chk("and_ovf_masked", resp_overflow1, 32'd0);
      chk("and_sticky_kept", ovf_sticky1, 32'd1);
      accept1();

      // stat_clr alone clears the sticky bit.
      stat_clr1 = 1'b1;
      @(posedge clk);
      #1 stat_clr1 = 1'b0;
      @(negedge clk);
      chk("stat_clr_clears", ovf_sticky1, 32'd0);

      // SUBU never traps.
      send1(6'h23, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      chk("subu_trap", resp_trap1, 32'd0);
      chk("subu_result", resp_result1, 32'h8000_0000);
      chk("subu_ovf", resp_overflow1, 32'd1);
      accept1();

      // SLT signed compare, flags masked.
      send1(6'h2A, 32'hFFFF_FFFE, 32'h0000_0001);
      @(negedge clk);
      @(negedge clk);
      chk("slt_result", resp_result1, 32'd1);
      chk("slt_ovf_masked", resp_overflow1, 32'd0);
      accept1();

      // NOR decode.
      send1(6'h27, 32'h0000_0000, 32'h0000_0000);
      @(negedge clk);
      chk("nor_alu_control", alu_control1, 32'hC);
      @(negedge clk);
      chk("nor_result", resp_result1, 32'hFFFF_FFFF);
      accept1();

      // Illegal funct: response one edge after acceptance, ALU untouched.
      send1(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      chk("ill_valid", resp_valid1, 32'd1);
      chk("ill_flag", resp_illegal1, 32'd1);
      chk("ill_result", resp_result1, 32'd0);
      chk("ill_zero", resp_zero1, 32'd0);
      chk("ill_alu_control", alu_control1, 32'hC);
      chk("ill_alu_src1", alu_src1_1, 32'd0);
      accept1();

      // SETTLE_CYCLES=4, response held with resp_ready low, new requests ignored.
      send4(6'h20, 32'h0000_0002, 32'h0000_0002);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s4_valid_not_yet", resp_valid4, 32'd0);
      end
      @(negedge clk);
      chk("s4_valid", resp_valid4, 32'd1);
      chk("s4_result", resp_result4, 32'd4);
      req_valid4 = 1'b1; req_funct4 = 6'h22; req_a4 = 32'd9; req_b4 = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("s4_hold_valid", resp_valid4, 32'd1);
         chk("s4_hold_result", resp_result4, 32'd4);
         chk("s4_hold_ready", req_ready4, 32'd0);
      end
      req_valid4 = 1'b0;
      chk("s4_alu_src1_unchanged", alu_src1_4, 32'd2);
      accept4();

      // Reset mid-WAIT abandons the overflowing add.
      send4(6'h20, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      @(negedge clk);
      rst4_n = 1'b0;
      @(negedge clk);
      rst4_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_wait_no_resp", resp_valid4, 32'd0);
         chk("rst_wait_sticky", ovf_sticky4, 32'd0);
      end

      // stat_clr coincident with an overflow capture: set wins.
      send4(6'h20, 32'h7FFF_FFFF, 32'h0000_0001);
      repeat (4) @(negedge clk);
      stat_clr4 = 1'b1;
      @(posedge clk);
      #1 stat_clr4 = 1'b0;
      @(negedge clk);
      chk("coinc_valid", resp_valid4, 32'd1);
      chk("coinc_ovf", resp_overflow4, 32'd1);
      chk("coinc_sticky", ovf_sticky4, 32'd1);
      chk("coinc_trap", resp_trap4, {31'd0, TRAP});
      chk("coinc_result", resp_result4, TRAP ? 32'd0 : 32'h8000_0000);
      accept4();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
